// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS sequencer: state encoding, latched
// decoder fields and next-PC select encodings.
package mips_mc_ctrl_pkg;

    localparam int unsigned SW = 3;

    typedef enum logic [SW-1:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StAddm   = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    // Next-PC select as produced by mips_decode.
    typedef enum logic [1:0] {
        CtSeq    = 2'd0,
        CtBranch = 2'd1,
        CtJump   = 2'd2,
        CtJreg   = 2'd3
    } ctrl_type_e;

    // Decoder outputs captured in DECODE and held for the rest of the instruction.
    typedef struct packed {
        logic       mem_read;
        logic       word_we;
        logic       byte_we;
        logic       addm;
        logic       writeenable;
        ctrl_type_e control_type;
    } ctrl_t;

    function automatic logic is_store(input ctrl_t c);
        return c.word_we | c.byte_we;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Handshake and control bundle between the sequencer and its surroundings
// (decoder, memories, datapath strobes).
interface mips_mc_ctrl_if;
    import mips_mc_ctrl_pkg::*;

    logic          imem_ready;
    logic          dmem_ready;
    logic          mem_read;
    logic          word_we;
    logic          byte_we;
    logic          addm;
    logic          writeenable;
    logic          except;
    logic [1:0]    control_type;

    logic          imem_req;
    logic          ir_we;
    logic          dmem_req;
    logic          dmem_we;
    logic          addm_phase;
    logic          rf_we;
    logic          pc_we;
    logic [1:0]    pc_sel;
    logic          halted;
    logic          timeout_err;
    logic [SW-1:0] state;

    modport master (
        input  imem_ready, dmem_ready, mem_read, word_we, byte_we, addm, writeenable, except,
               control_type,
        output imem_req, ir_we, dmem_req, dmem_we, addm_phase, rf_we, pc_we, pc_sel, halted,
               timeout_err, state
    );

    modport slave (
        output imem_ready, dmem_ready, mem_read, word_we, byte_we, addm, writeenable, except,
               control_type,
        input  imem_req, ir_we, dmem_req, dmem_we, addm_phase, rf_we, pc_we, pc_sel, halted,
               timeout_err, state
    );

endinterface

// File: rtl/mips_mc_ctrl_wait_timer.sv
// Memory wait counter shared by the instruction-fetch and data-access waits.
// Any cycle that is not a wait clears it, so each FETCH/MEM entry starts at 0.
module mips_mc_ctrl_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic wait_i,
    output logic expired_o
);
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CntMax);

    // Count waiting cycles, saturating at the limit; clear otherwise.
    always_comb begin
        cnt_d = '0;
        if (wait_i) begin
            cnt_d = expired_o ? cnt_q : cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle sequencer: FETCH, DECODE, EXEC, optional MEM/ADDM, WB, with
// variable-latency memory handshakes and a sticky HALT on exception or timeout.
module mips_mc_ctrl
    import mips_mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input logic            clk_i,
    input logic            reset_ni,
    mips_mc_ctrl_if.master bus_io
);
    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   timeout_err_q, timeout_err_d;
    logic   mem_wait, expired, timeout;

    assign mem_wait = ((state_q == StFetch) && !bus_io.imem_ready) ||
                      ((state_q == StMem) && !bus_io.dmem_ready);
    // Ready wins over the timeout because mem_wait is already low when ready is high.
    assign timeout  = mem_wait & expired;

    mips_mc_ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .wait_i    (mem_wait),
        .expired_o (expired)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched decoder fields and sticky timeout flag.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ctrl_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state and field-capture logic.
    always_comb begin
        state_d       = state_q;
        ctrl_d        = ctrl_q;
        timeout_err_d = timeout_err_q | timeout;
        case (state_q)
            StFetch: begin
                if (bus_io.imem_ready) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StHalt;
                end
            end
            StDecode: begin
                ctrl_d.mem_read     = bus_io.mem_read;
                ctrl_d.word_we      = bus_io.word_we;
                ctrl_d.byte_we      = bus_io.byte_we;
                ctrl_d.addm         = bus_io.addm;
                ctrl_d.writeenable  = bus_io.writeenable;
                ctrl_d.control_type = ctrl_type_e'(bus_io.control_type);
                state_d             = bus_io.except ? StHalt : StExec;
            end
            StExec: begin
                state_d = (ctrl_q.mem_read || is_store(ctrl_q)) ? StMem : StWb;
            end
            StMem: begin
                if (bus_io.dmem_ready) begin
                    state_d = ctrl_q.addm ? StAddm : StWb;
                end else if (timeout) begin
                    state_d = StHalt;
                end
            end
            StAddm:  state_d = StWb;
            StWb:    state_d = StFetch;
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    // Outputs decoded from registered state; forced low while reset is held.
    always_comb begin
        bus_io.imem_req    = 1'b0;
        bus_io.ir_we       = 1'b0;
        bus_io.dmem_req    = 1'b0;
        bus_io.dmem_we     = 1'b0;
        bus_io.addm_phase  = 1'b0;
        bus_io.rf_we       = 1'b0;
        bus_io.pc_we       = 1'b0;
        bus_io.pc_sel      = CtSeq;
        bus_io.halted      = 1'b0;
        bus_io.timeout_err = 1'b0;
        bus_io.state       = '0;
        if (reset_ni) begin
            bus_io.state       = state_q;
            bus_io.timeout_err = timeout_err_q;
            case (state_q)
                StFetch: begin
                    bus_io.imem_req = 1'b1;
                    bus_io.ir_we    = bus_io.imem_ready;
                end
                StMem: begin
                    bus_io.dmem_req = 1'b1;
                    bus_io.dmem_we  = is_store(ctrl_q);
                end
                StAddm: bus_io.addm_phase = 1'b1;
                StWb: begin
                    bus_io.pc_we  = 1'b1;
                    bus_io.pc_sel = ctrl_q.control_type;
                    bus_io.rf_we  = ctrl_q.writeenable & ~is_store(ctrl_q);
                end
                StHalt:  bus_io.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench: each instruction pushes its expected per-cycle output
// vector (with the memory readies to drive); the driver pops and compares.
module tb_mips_mc_ctrl;
    import mips_mc_ctrl_pkg::*;

    localparam int unsigned TO = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mips_mc_ctrl_if bus_if ();

    mips_mc_ctrl #(
        .TIMEOUT (TO)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus_io   (bus_if)
    );

    typedef struct packed {
        logic        iready;
        logic        dready;
        logic        dec;
        logic        mr;
        logic        ww;
        logic        bw;
        logic        am;
        logic        we;
        logic        ex;
        logic [1:0]  ct;
        logic [13:0] exp;
    } step_t;

    step_t sb_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    // Vector: state, imem_req, ir_we, dmem_req, dmem_we, addm_phase, rf_we, pc_we,
    // pc_sel, halted, timeout_err.
    function automatic logic [13:0] obs();
        return {bus_if.state, bus_if.imem_req, bus_if.ir_we, bus_if.dmem_req, bus_if.dmem_we,
                bus_if.addm_phase, bus_if.rf_we, bus_if.pc_we, bus_if.pc_sel, bus_if.halted,
                bus_if.timeout_err};
    endfunction

    function automatic logic [13:0] mk(input logic [2:0] st, input logic [6:0] strb,
                                       input logic [1:0] ps, input logic hl, input logic to);
        return {st, strb, ps, hl, to};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic push_halt(input step_t base, input logic to, input int n);
        step_t s;
        s = base;
        s.dec = 1'b0;
        for (int i = 0; i < n; i++) begin
            s.iready = 1'($urandom);
            s.dready = 1'($urandom);
            s.exp    = mk(3'd6, 7'b0000000, 2'd0, 1'b1, to);
            sb_q.push_back(s);
        end
    endtask

    // iw/dw: memory wait cycles; a value >= TO models a memory that never answers.
    task automatic push_instr(input logic mr, ww, bw, am, we, ex, input logic [1:0] ct,
                              input int iw, input int dw);
        step_t s;
        logic  sto;
        sto  = ww | bw;
        s    = '0;
        s.mr = mr; s.ww = ww; s.bw = bw; s.am = am; s.we = we; s.ex = ex; s.ct = ct;
        for (int i = 0; i < iw && i < TO; i++) begin
            s.iready = 1'b0;
            s.dready = 1'($urandom);
            s.exp    = mk(3'd0, 7'b1000000, 2'd0, 1'b0, 1'b0);
            sb_q.push_back(s);
        end
        if (iw >= TO) begin
            push_halt(s, 1'b1, 4);
            return;
        end
        s.iready = 1'b1;
        s.exp    = mk(3'd0, 7'b1100000, 2'd0, 1'b0, 1'b0);
        sb_q.push_back(s);
        s.dec    = 1'b1;
        s.iready = 1'($urandom);
        s.exp    = mk(3'd1, 7'b0000000, 2'd0, 1'b0, 1'b0);
        sb_q.push_back(s);
        s.dec    = 1'b0;
        if (ex) begin
            push_halt(s, 1'b0, 20);
            return;
        end
        s.iready = 1'($urandom);
        s.dready = 1'($urandom);
        s.exp    = mk(3'd2, 7'b0000000, 2'd0, 1'b0, 1'b0);
        sb_q.push_back(s);
        if (mr | sto) begin
            for (int i = 0; i < dw && i < TO; i++) begin
                s.iready = 1'($urandom);
                s.dready = 1'b0;
                s.exp    = mk(3'd3, {3'b001, sto, 3'b000}, 2'd0, 1'b0, 1'b0);
                sb_q.push_back(s);
            end
            if (dw >= TO) begin
                push_halt(s, 1'b1, 4);
                return;
            end
            s.dready = 1'b1;
            s.exp    = mk(3'd3, {3'b001, sto, 3'b000}, 2'd0, 1'b0, 1'b0);
            sb_q.push_back(s);
            if (am) begin
                s.dready = 1'($urandom);
                s.exp    = mk(3'd4, 7'b0000100, 2'd0, 1'b0, 1'b0);
                sb_q.push_back(s);
            end
        end
        s.iready = 1'($urandom);
        s.dready = 1'($urandom);
        s.exp    = mk(3'd5, {5'b00000, we & ~sto, 1'b1}, ct, 1'b0, 1'b0);
        sb_q.push_back(s);
    endtask

    // Called on a negedge; consumes up to limit steps, one per clock.
    task automatic run_sb(input string name, input int limit);
        step_t s;
        int    c;
        c = 0;
        while (sb_q.size() > 0 && c < limit) begin
            s = sb_q.pop_front();
            bus_if.imem_ready = s.iready;
            bus_if.dmem_ready = s.dready;
            if (s.dec) begin
                {bus_if.mem_read, bus_if.word_we, bus_if.byte_we, bus_if.addm,
                 bus_if.writeenable, bus_if.except, bus_if.control_type} =
                    {s.mr, s.ww, s.bw, s.am, s.we, s.ex, s.ct};
            end else begin
                // Decoder fields are only meaningful in DECODE; scramble them elsewhere.
                {bus_if.mem_read, bus_if.word_we, bus_if.byte_we, bus_if.addm,
                 bus_if.writeenable, bus_if.except, bus_if.control_type} = 8'($urandom);
            end
            #1;
            check($sformatf("%s cyc%0d", name, c), 32'(obs()), 32'(s.exp));
            c++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string name);
        reset_n           = 1'b0;
        bus_if.imem_ready = 1'b1;
        bus_if.dmem_ready = 1'b1;
        #1;
        check({name, " rst_now"}, 32'(obs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({name, " rst_held"}, 32'(obs()), 32'd0);
        reset_n = 1'b1;
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        {bus_if.imem_ready, bus_if.dmem_ready, bus_if.mem_read, bus_if.word_we,
         bus_if.byte_we, bus_if.addm, bus_if.writeenable, bus_if.except} = '0;
        bus_if.control_type = 2'd0;
        @(negedge clk);
        do_reset("init");

        // mr ww bw am we ex ct iw dw
        push_instr(0, 0, 0, 0, 1, 0, 2'd0, 0, 0);  run_sb("add", 1000);
        push_instr(1, 0, 0, 0, 1, 0, 2'd0, 0, 3);  run_sb("lw", 1000);
        push_instr(0, 0, 1, 0, 0, 0, 2'd0, 0, 1);  run_sb("sb", 1000);
        push_instr(0, 1, 0, 0, 1, 0, 2'd1, 2, 0);  run_sb("sw", 1000);
        push_instr(1, 0, 0, 1, 1, 0, 2'd2, 0, 0);  run_sb("addm", 1000);
        push_instr(0, 0, 0, 1, 0, 0, 2'd3, 1, 0);  run_sb("jr", 1000);

        push_instr(0, 0, 0, 0, 1, 1, 2'd1, 0, 0);  run_sb("except", 1000);
        do_reset("except");

        push_instr(0, 0, 0, 0, 1, 0, 2'd0, TO, 0); run_sb("itimeout", 1000);
        do_reset("itimeout");

        push_instr(0, 0, 0, 0, 1, 0, 2'd2, TO - 1, 0); run_sb("ilast", 1000);

        push_instr(1, 0, 0, 0, 1, 0, 2'd0, 0, TO); run_sb("dtimeout", 1000);
        do_reset("dtimeout");

        push_instr(0, 0, 0, 0, 0, 0, 2'd0, 0, TO - 1); run_sb("dnoop", 1000);
        push_instr(1, 0, 0, 0, 1, 0, 2'd0, 0, TO - 1); run_sb("dlast", 1000);

        // Abort a load while it waits in MEM.
        push_instr(1, 0, 0, 0, 1, 0, 2'd1, 0, 5);  run_sb("abort", 5);
        do_reset("abort");

        for (int k = 0; k < 24; k++) begin
            logic [7:0] r;
            r = 8'($urandom);
            push_instr(r[0], r[1] & ~r[2], r[2], r[3], r[4], 1'b0, r[6:5],
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        run_sb("rand", 10000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
